ula_sequencial: RTL
===================

# ula_sequencial

Parametrised, registered successor of the 1-bit ULA. It supports WIDTH-bit operands, a valid/ready input handshake, status flags and an optional iterative multiplier. It sits between the operand registers and the writeback stage of the datapath. Single-cycle operations return one cycle after acceptance; multiplication stalls the input for WIDTH cycles.

## Interface
- WIDTH, 8: operand and result width in bits, at least 2.
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- entrada1  input  WIDTH  operand A.
- entrada2  input  WIDTH  operand B.
- seletor  input  3  operation code:
  - 000 soma
  - 001 subtracao
  - 010 and
  - 011 or
  - 100 multiplicacao
  - all other codes are invalid.
- valido_entrada  input  1  request valid.
- pronto  output  1  ready to accept a request.
- saida  output  WIDTH  registered result.
- valido_saida  output  1  one-cycle pulse: saida and flags are new.
- zero, negativo, vai_um, overflow, erro  output  1 each  registered status flags.

## Operation
- Acceptance: valido_entrada and pronto are both 1 at a rising edge. Operands and seletor are sampled only at acceptance. A request made while pronto=0 is dropped, not queued.
- pronto = (estado == OCIOSO) and not reset.
- States:
  - OCIOSO:
    - Single-cycle op accepted: stay in OCIOSO and write results.
    - 100 accepted: load operands, set contador=0 and go to MULTIPLICA.
  - MULTIPLICA:
    - One shift-add step per edge; contador increments.
    - On the edge where contador reaches WIDTH-1, write results and return to OCIOSO.
- Arithmetic is two's complement modulo 2^WIDTH. The product uses a 2·WIDTH-bit accumulator; saida takes its low WIDTH bits.
- Flags are written together with saida and held until the next result:
  - zero = (saida == 0).
  - negativo = saida[WIDTH-1].
  - vai_um:
    - soma: carry out.
    - subtracao: borrow, i.e. entrada1 < entrada2 unsigned.
    - all other ops: 0.
  - overflow:
    - soma and subtracao: signed overflow.
    - multiplicacao: upper WIDTH product bits nonzero (unsigned).
    - and, or: 0.
  - erro = 1 only for an invalid seletor. In that case saida=0, zero=1, other flags 0, and valido_saida still pulses.
- Reset, including mid-multiplication:
  - estado goes to OCIOSO, the accumulator and contador are cleared, and the pending result is discarded.
  - saida=0 and all flags=0.
  - No valido_saida pulse for the aborted request.

## Timing
- Reset values: saida=0, valido_saida=0, all flags=0, pronto=0 while reset is asserted.
- pronto=1 in the first cycle after reset deasserts.
- Single-cycle ops:
  - Accepted at edge k: result is visible after edge k, and valido_saida=1 for that cycle only.
  - Back-to-back acceptance every cycle is allowed. valido_saida then stays high on consecutive cycles.
- Multiplication:
  - Accepted at edge k: pronto=0 from after edge k until edge k+WIDTH.
  - Result and valido_saida=1 appear after edge k+WIDTH; pronto returns to 1 in that same cycle.
  - A new request can be accepted at edge k+WIDTH+1.
- Reset asserted together with valido_entrada: reset wins and the request is ignored.
- saida is stable between valido_saida pulses.

## Configuration
- ULA_MULT_EN defined:
  - The multiplier, the MULTIPLICA state and contador are compiled in.
  - seletor=100 performs multiplication.
- ULA_MULT_EN undefined:
  - No multiplier logic; the FSM never leaves OCIOSO, so pronto=1 whenever reset=0.
  - seletor=100 is treated as invalid: one-cycle latency, saida=0, erro=1.

## Test plan
All cases use WIDTH=8.
1. soma FF+01 → saida=00, zero=1, vai_um=1, overflow=0, valido_saida 1 cycle after accept.
2. subtracao 80−01 → saida=7F, overflow=1, vai_um=0, negativo=0. Then subtracao 01−02 → FF, vai_um=1, negativo=1.
3. and AA,0F then or AA,0F on consecutive cycles → 0A then AF, with valido_saida high two consecutive cycles.
4. ULA_MULT_EN defined:
   - mult 0F×11 → FF, overflow=0, pronto low 8 cycles, result 8 cycles after accept.
   - A soma request during the busy period is dropped.
   - mult 10×10 → 00, zero=1, overflow=1.
5. Reset asserted 3 cycles into a multiplication → saida=0, flags=0, no valido_saida, pronto=1 the cycle after reset deasserts; the next soma 02+03 → 05.
6. seletor=101 → saida=00, erro=1, zero=1. Without ULA_MULT_EN, seletor=100 → same response with 1-cycle latency.

Source files
------------

// File: rtl/ula_sequencial_if.sv
// rtl/ula_sequencial_if.sv - request/result bus of the sequential ULA
//
// Groups the operand request handshake (entrada1, entrada2, seletor,
// valido_entrada / pronto) and the registered result with its status flags
// (saida, valido_saida, zero, negativo, vai_um, overflow, erro).
//   master : operand-register side, drives the request and observes the result
//   slave  : the ULA itself
interface ula_sequencial_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] entrada1;
   logic [WIDTH-1:0] entrada2;
   logic [2:0]       seletor;
   logic             valido_entrada;
   logic             pronto;
   logic [WIDTH-1:0] saida;
   logic             valido_saida;
   logic             zero;
   logic             negativo;
   logic             vai_um;
   logic             overflow;
   logic             erro;

   modport master (
      output entrada1, entrada2, seletor, valido_entrada,
      input  pronto, saida, valido_saida, zero, negativo, vai_um, overflow, erro
   );

   modport slave (
      input  entrada1, entrada2, seletor, valido_entrada,
      output pronto, saida, valido_saida, zero, negativo, vai_um, overflow, erro
   );
endinterface

// File: rtl/ula_sequencial.sv
// rtl/ula_sequencial.sv - registered WIDTH-bit ULA with valid/ready input and flags
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : ula_sequencial_if.slave (operands, seletor, handshake, result, flags)
// seletor: 000 soma, 001 subtracao, 010 and, 011 or, 100 multiplicacao,
// anything else raises erro with saida=0.
// Build option: define ULA_MULT_EN to compile in the iterative shift-add
// multiplier (WIDTH cycles, input stalled meanwhile). Without it seletor=100
// is treated as an invalid code.
module ula_sequencial #(
   parameter int WIDTH = 8
) (
   input  logic            clock,
   input  logic            reset,
   ula_sequencial_if.slave bus
);
   logic [WIDTH-1:0] saida_r;
   logic             valido_r;
   logic             zero_r;
   logic             negativo_r;
   logic             vai_um_r;
   logic             overflow_r;
   logic             erro_r;

   logic             aceita;
   logic [WIDTH:0]   soma_ext;
   logic [WIDTH:0]   sub_ext;
   logic [WIDTH-1:0] res_c;
   logic             vai_um_c;
   logic             overflow_c;
   logic             erro_c;
   logic             sa;
   logic             sb;

`ifdef ULA_MULT_EN
   localparam logic [0:0] OCIOSO     = 1'b0;
   localparam logic [0:0] MULTIPLICA = 1'b1;
   localparam int         CW         = $clog2(WIDTH);

   logic [0:0]         estado;
   logic [CW-1:0]      contador;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_prox;
   logic [WIDTH-1:0]   mplier;

   // mcand walks left and mplier walks right, so bit 0 of mplier always
   // selects whether the current partial product is added.
   assign acc_prox  = mplier[0] ? (acc + mcand) : acc;
   assign bus.pronto = (estado == OCIOSO) && !reset;
`else
   assign bus.pronto = !reset;
`endif

   assign aceita = bus.valido_entrada && bus.pronto;

   always_comb begin
      sa         = bus.entrada1[WIDTH-1];
      sb         = bus.entrada2[WIDTH-1];
      soma_ext   = {1'b0, bus.entrada1} + {1'b0, bus.entrada2};
      sub_ext    = {1'b0, bus.entrada1} - {1'b0, bus.entrada2};
      res_c      = '0;
      vai_um_c   = 1'b0;
      overflow_c = 1'b0;
      erro_c     = 1'b0;
      case (bus.seletor)
         3'b000: begin
            res_c      = soma_ext[WIDTH-1:0];
            vai_um_c   = soma_ext[WIDTH];
            overflow_c = (sa == sb) && (soma_ext[WIDTH-1] != sa);
         end
         3'b001: begin
            // bit WIDTH of the zero-extended difference is the unsigned borrow
            res_c      = sub_ext[WIDTH-1:0];
            vai_um_c   = sub_ext[WIDTH];
            overflow_c = (sa != sb) && (sub_ext[WIDTH-1] != sa);
         end
         3'b010:  res_c  = bus.entrada1 & bus.entrada2;
         3'b011:  res_c  = bus.entrada1 | bus.entrada2;
         default: erro_c = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         saida_r    <= '0;
         valido_r   <= 1'b0;
         zero_r     <= 1'b0;
         negativo_r <= 1'b0;
         vai_um_r   <= 1'b0;
         overflow_r <= 1'b0;
         erro_r     <= 1'b0;
`ifdef ULA_MULT_EN
         estado     <= OCIOSO;
         contador   <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
`endif
      end else begin
         valido_r <= 1'b0;
`ifdef ULA_MULT_EN
         if (estado == MULTIPLICA) begin
            acc      <= acc_prox;
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            contador <= contador + 1'b1;
            if (contador == CW'(WIDTH - 1)) begin
               saida_r    <= acc_prox[WIDTH-1:0];
               zero_r     <= (acc_prox[WIDTH-1:0] == '0);
               negativo_r <= acc_prox[WIDTH-1];
               vai_um_r   <= 1'b0;
               overflow_r <= |acc_prox[2*WIDTH-1:WIDTH];
               erro_r     <= 1'b0;
               valido_r   <= 1'b1;
               estado     <= OCIOSO;
            end
         end
         // aceita implies OCIOSO, so this never overlaps the step above
         if (aceita && bus.seletor == 3'b100) begin
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, bus.entrada1};
            mplier   <= bus.entrada2;
            contador <= '0;
            estado   <= MULTIPLICA;
         end else
`endif
         if (aceita) begin
            saida_r    <= res_c;
            zero_r     <= (res_c == '0);
            negativo_r <= res_c[WIDTH-1];
            vai_um_r   <= vai_um_c;
            overflow_r <= overflow_c;
            erro_r     <= erro_c;
            valido_r   <= 1'b1;
         end
      end
   end

   assign bus.saida        = saida_r;
   assign bus.valido_saida = valido_r;
   assign bus.zero         = zero_r;
   assign bus.negativo     = negativo_r;
   assign bus.vai_um       = vai_um_r;
   assign bus.overflow     = overflow_r;
   assign bus.erro         = erro_r;
endmodule
